// File: rtl/timer_pkg.sv
// timer_pkg: shared types and BCD constants for the keypad-driven countdown timer
package timer_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam digit_t BCD_0 = 4'd0;
    localparam digit_t BCD_5 = 4'd5;
    localparam digit_t BCD_9 = 4'd9;

endpackage

// File: rtl/bcd_countdown.sv
// bcd_countdown: combinational one-second decrement of an MM:SS BCD value
import timer_pkg::*;

module bcd_countdown (
    input  digit_t min_tens,
    input  digit_t min_ones,
    input  digit_t sec_tens,
    input  digit_t sec_ones,
    output digit_t dec_min_tens,
    output digit_t dec_min_ones,
    output digit_t dec_sec_tens,
    output digit_t dec_sec_ones,
    output logic   zero
);

    // Borrow ripples from the lowest nonzero digit; seconds reload to 59 and 0000 holds
    always_comb begin
        zero = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
        dec_min_tens = min_tens;
        dec_min_ones = min_ones;
        dec_sec_tens = sec_tens;
        dec_sec_ones = sec_ones;
        if (sec_ones != BCD_0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else if (sec_tens != BCD_0) begin
            dec_sec_tens = sec_tens - 4'd1;
            dec_sec_ones = BCD_9;
        end else if (min_ones != BCD_0) begin
            dec_min_ones = min_ones - 4'd1;
            dec_sec_tens = BCD_5;
            dec_sec_ones = BCD_9;
        end else if (min_tens != BCD_0) begin
            dec_min_tens = min_tens - 4'd1;
            dec_min_ones = BCD_9;
            dec_sec_tens = BCD_5;
            dec_sec_ones = BCD_9;
        end
    end

endmodule

// File: rtl/digit_timer.sv
// digit_timer: captures keypad BCD digits into MM:SS and counts down on the encoder tick
import timer_pkg::*;

module digit_timer (
    input  logic   clk,
    input  logic   clear,
    input  digit_t D,
    input  logic   loadn,
    input  logic   pgt,
    input  logic   start,
    input  logic   stop,
    input  logic   door_open,
    output logic   enbn,
    output digit_t min_tens,
    output digit_t min_ones,
    output digit_t sec_tens,
    output digit_t sec_ones,
    output logic   running,
    output logic   done
);

    state_t state;
    logic   pgt_q, start_q, stop_q;
    digit_t dec_mt, dec_mo, dec_st, dec_so;
    logic   zero;

    wire pgt_ev   = pgt & ~pgt_q;
    wire start_ev = start & ~start_q;
    wire stop_ev  = stop & ~stop_q;
    wire key_ev   = pgt_ev & ~loadn & (D <= BCD_9);
    wire reach    = {dec_mt, dec_mo, dec_st, dec_so} == 16'h0000;

    bcd_countdown u_dec (
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .dec_min_tens(dec_mt),
        .dec_min_ones(dec_mo),
        .dec_sec_tens(dec_st),
        .dec_sec_ones(dec_so),
        .zero        (zero)
    );

    // Delayed copies of the strobes so a held level yields a single event
    always_ff @(posedge clk) begin
        if (clear) begin
            pgt_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            pgt_q   <= pgt;
            start_q <= start;
            stop_q  <= stop;
        end
    end

    // Mode FSM owning the digit register; status outputs move with each transition
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
            enbn    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stop_ev) begin
                        {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                    end else begin
                        if (key_ev)
                            {min_tens, min_ones, sec_tens, sec_ones} <= {min_ones, sec_tens, sec_ones, D};
                        if (start_ev && !zero && !door_open) begin
                            state   <= RUN;
                            enbn    <= 1'b1;
                            running <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop_ev) begin
                        state   <= PAUSE;
                        enbn    <= 1'b0;
                        running <= 1'b0;
                    end else begin
                        if (pgt_ev)
                            {min_tens, min_ones, sec_tens, sec_ones} <= {dec_mt, dec_mo, dec_st, dec_so};
                        if (pgt_ev && reach) begin
                            state   <= DONE;
                            enbn    <= 1'b0;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (door_open) begin
                            state   <= PAUSE;
                            enbn    <= 1'b0;
                            running <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (stop_ev) begin
                        state <= IDLE;
                        {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                    end else if (start_ev && !door_open) begin
                        state   <= RUN;
                        enbn    <= 1'b1;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop_ev) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (key_ev) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        {min_tens, min_ones, sec_tens, sec_ones} <= {min_ones, sec_tens, sec_ones, D};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/digit_timer.md
# digit_timer

Receiving end of the keypad encoder interface. It captures BCD digits from the encoder's `D`/`loadn`/`pgt` outputs into a four-digit MM:SS register, then counts that time down using the same `pgt` line, which the encoder switches to its divided tick while the keypad is disabled. It drives the encoder's keypad enable, so entry and countdown never overlap. It also provides the display digits and run/done status to the microwave control logic.

## Interface
Parameters:
- none; all widths are fixed by the BCD keypad interface.

Ports:
- `clk`  in  1  system clock; every register is clocked on the rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `D`  in  4  BCD digit from the encoder; values 10–15 are invalid.
- `loadn`  in  1  active-low key-valid from the encoder.
- `pgt`  in  1  encoder strobe: key pulse during entry, 1 Hz tick during countdown.
- `start`  in  1  start request; rising-edge detected internally.
- `stop`  in  1  stop/cancel request; rising-edge detected internally.
- `door_open`  in  1  level input; high means the door is open.
- `enbn`  out  1  keypad disable to the encoder; high in RUN.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD display digits.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE (alarm).

## Operation
- Edge detection: `pgt`, `start` and `stop` are each registered once. An event is signal=1 while the registered copy=0.
- States are IDLE, RUN, PAUSE and DONE. Reset enters IDLE.
- Reset values: all digits 0, `enbn`=0, `running`=0, `done`=0.
- IDLE:
  - Digit entry: a `pgt` event with `loadn`=0 and `D`≤9 shifts the digits left. `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`D`.
  - `D`>9, or `loadn`=1, means no shift.
  - A `start` event with a nonzero register and `door_open`=0 moves to RUN. A `start` event with the register at 0000 is ignored.
  - A `stop` event clears all digits to 0.
- RUN:
  - Each `pgt` event decrements the MM:SS value.
  - On reaching 0000, move to DONE.
  - A `stop` event moves to PAUSE.
  - `door_open`=1 moves to PAUSE.
- PAUSE:
  - Digits are held, and digit events are ignored.
  - A `start` event with `door_open`=0 moves to RUN.
  - A `stop` event clears all digits and moves to IDLE.
- DONE:
  - Digits stay at 0000.
  - A `stop` event moves to IDLE.
  - A valid digit event moves to IDLE and performs the shift in the same cycle.
- Decrement rule:
  - `sec_ones`>0: decrement `sec_ones`.
  - Otherwise, if `sec_tens`>0: decrement `sec_tens` and set `sec_ones`=9.
  - Otherwise, if minutes>0: decrement the minutes as BCD and set seconds to 59.
  - Seconds above 59 are legal and count down as entered (0099 gives 99 s).
  - 0000 never decrements, so the value never wraps below zero.
- Simultaneous events:
  - `stop` beats `start`.
  - `stop` in RUN suppresses a coincident tick; no decrement happens.
  - `door_open` beats `start`.
  - A tick that reaches 0000 in the same cycle as `door_open` rising goes to DONE.
- `clear` beats everything and may be asserted in any state.

## Timing
- Input events are detected in the cycle the input is first seen high; registered outputs change on the following clock edge. Latency is 1 cycle from the input edge to the output update.
- `enbn` and `running` rise in the same edge that enters RUN and fall in the same edge that leaves it. The encoder's mux therefore selects the tick from the next cycle onward.
- `done` rises in the edge that enters DONE, with the digits reading 0000 in the same cycle.
- A level held high on `pgt`, `start` or `stop` produces exactly one event.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - BCD constants for 0, 5 and 9 and the 4-bit digit type.
- Sub-module `bcd_countdown` is combinational. It takes the four digits and produces the decremented digits plus a zero flag. `digit_timer` instantiates it once.
- `digit_timer` holds the state machine, the edge detectors and the digit registers.

## Test plan
- Reset, then digits 1,2,3,0 entered → display reads 12:30; `enbn`=0; `running`=0.
- Entry of `D`=11, and a `pgt` event with `loadn`=1 → no shift.
- Load 0003, `start`, 3 ticks → reads 0002, 0001, 0000, then `done`=1, `enbn`=0.
- Load 0100, `start`, 1 tick → reads 00:59. Load 0099, 1 tick → reads 00:98.
- Raise `door_open` in RUN → PAUSE with digits held. `start` while `door_open`=1 is ignored. `start` after the door closes resumes counting.
- `start` and `stop` in the same cycle in RUN → PAUSE with no decrement. `clear` mid-RUN → IDLE with 0000 in the next cycle.
